nios_system_sysid_reader: RTL and testbench
===========================================

NIOS_SYSTEM_SYSID_READER -- requirements
Module: nios_system_sysid_reader

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd1738232517, the system ID value the read-back is compared against.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, legal range 1..65535, the cycles allowed per read phase.
REQ-003 SHALL have port clock  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  in  1  requests one ID/timestamp read sequence.
REQ-006 SHALL have port avm_address  out  1  Avalon-MM word address: 0 = system ID, 1 = timestamp.
REQ-007 SHALL have port avm_read  out  1  Avalon-MM read request.
REQ-008 SHALL have port avm_waitrequest  in  1  slave stall; a request is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-009 SHALL have port avm_readdatavalid  in  1  marks avm_readdata as valid.
REQ-010 SHALL have port avm_readdata  in  32  read data.
REQ-011 SHALL have port id_value  out  32  captured system ID.
REQ-012 SHALL have port timestamp  out  32  captured timestamp.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse at sequence end, whether it succeeded or timed out.
REQ-015 SHALL have port id_match  out  1  sticky; 1 when id_value equals EXPECTED_ID after a successful sequence.
REQ-016 SHALL have port timeout  out  1  sticky; 1 when the last sequence was aborted by a timeout.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS and FINISH.
REQ-018 IDLE SHALL go to REQ_ID when start=1, clearing id_match and timeout in the same cycle.
REQ-019 start sampled in cycle N SHALL give avm_read=1 with avm_address=0 in cycle N+1.
REQ-020 REQ_ID SHALL hold avm_read=1 and avm_address=0 constant until acceptance, then go to WAIT_ID.
REQ-021 WAIT_ID SHALL capture avm_readdata into id_value on avm_readdatavalid=1, then go to REQ_TS.
REQ-022 REQ_TS and WAIT_TS SHALL mirror REQ_ID and WAIT_ID, with avm_address=1 and capture into timestamp.
REQ-023 If avm_readdatavalid=1 coincides with acceptance (zero-latency slave), the data SHALL be captured in that cycle and the WAIT state skipped.
REQ-024 FINISH SHALL assert done for one cycle, set id_match=(id_value==EXPECTED_ID), and return to IDLE.
REQ-025 avm_read SHALL be 0 in IDLE, WAIT_ID, WAIT_TS and FINISH; at most one read is outstanding at any time.
REQ-026 A 16-bit phase counter SHALL clear on entry to REQ_ID and REQ_TS and increment every cycle of that phase.
REQ-027 If the counter reaches TIMEOUT_CYCLES-1 without data capture, the FSM SHALL next enter IDLE with timeout=1, done pulsed, id_match=0 and avm_read dropped.
REQ-028 Data capture in the same cycle as the timeout threshold SHALL take precedence over the timeout.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 avm_readdatavalid in IDLE, REQ_ID or REQ_TS with no coincident acceptance SHALL be ignored.
REQ-031 id_value and timestamp SHALL hold their last captured values until the next capture.

Reset
REQ-032 On reset=1 the FSM SHALL enter IDLE immediately, asynchronously.
REQ-033 On reset=1 all outputs SHALL be 0 and the phase counter SHALL be 0.
REQ-034 Reset in mid-sequence SHALL abandon any outstanding read without a done pulse; a late avm_readdatavalid is ignored under REQ-030.

Structure
REQ-035 State encodings and the address constants ADDR_ID=0 and ADDR_TS=1 SHALL live in a shared include file used by the RTL and the bench.
REQ-036 The phase counter and its timeout compare SHALL be the sub-module nios_system_sysid_reader_timer (ports: clear, enable, expired).

Verification
REQ-037 Zero-wait slave (avm_waitrequest=0, readdatavalid in the accept cycle), ID 1738232517, timestamp 1234: done in cycle N+3, id_match=1, timestamp=1234, timeout=0.
REQ-038 avm_waitrequest held 3 cycles per read, readdatavalid 2 cycles after acceptance: address and read stay stable while stalled; done=1 and id_match=1.
REQ-039 Slave returns ID 0: done=1, id_match=0, id_value=0.
REQ-040 TIMEOUT_CYCLES=8, readdatavalid never asserted after the ID read: avm_read drops and timeout=1, done=1 after 8 WAIT-phase cycles; the next start clears timeout.
REQ-041 Reset asserted in WAIT_TS, then readdatavalid asserted: outputs are 0, no done pulse, the FSM stays in IDLE.
REQ-042 start pulsed again in REQ_TS: no extra sequence runs and exactly one done pulse is seen.

Source files
------------

// File: rtl/nios_system_sysid_reader_pkg.sv
// Shared definitions for the system ID / timestamp reader.
// Holds the FSM state encoding, the Avalon-MM word addresses of the two
// sysid registers and the phase counter width. Imported by the RTL and
// by the testbench so both agree on encodings.
package nios_system_sysid_reader_pkg;

  // FSM states of the read sequence
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ID  = 3'd1,
    WAIT_ID = 3'd2,
    REQ_TS  = 3'd3,
    WAIT_TS = 3'd4,
    FINISH  = 3'd5
  } state_e;

  // Word addresses inside the sysid slave
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Width of the per-phase cycle counter
  localparam int unsigned PHASE_CNT_W = 16;

  // True in the states that present a read request on the bus
  function automatic logic is_request(input state_e s);
    return (s == REQ_ID) || (s == REQ_TS);
  endfunction

endpackage

// File: rtl/nios_system_sysid_reader_timer.sv
// Phase timer for the sysid reader.
// Counts cycles spent in one read phase (request plus wait) and flags
// when the phase has used up its budget of TIMEOUT_CYCLES cycles.
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-high reset, clears the count
//   clear   - restart the count at zero on the next edge (phase entry)
//   enable  - a phase is in progress, count this cycle
//   expired - this is the last cycle of the phase budget
module nios_system_sysid_reader_timer
  import nios_system_sysid_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [PHASE_CNT_W-1:0] LIMIT = PHASE_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [PHASE_CNT_W-1:0] count_d;
  logic [PHASE_CNT_W-1:0] count_q;

  // Clear wins over counting so a phase that starts right after another
  // one always begins at zero. The FSM leaves the phase at LIMIT, so the
  // counter never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // First phase cycle sees count 0, so LIMIT is reached on cycle
  // number TIMEOUT_CYCLES of the phase.
  assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/nios_system_sysid_reader.sv
// Reads the system ID and then the timestamp from an Avalon-MM sysid
// slave, one outstanding read at a time, and reports whether the ID
// matches EXPECTED_ID. Each read phase is bounded by a cycle budget.
// Ports:
//   clock, reset         - clock and asynchronous active-high reset
//   start                - request one ID/timestamp sequence (ignored while busy)
//   avm_*                - Avalon-MM read master (address 0 = ID, 1 = timestamp)
//   id_value, timestamp  - last captured values
//   busy                 - sequence in progress
//   done                 - one-cycle pulse at sequence end (success or timeout)
//   id_match             - sticky, ID equalled EXPECTED_ID on the last success
//   timeout              - sticky, last sequence was aborted by the timer
module nios_system_sysid_reader
  import nios_system_sysid_reader_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd1738232517,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        timeout
);

  state_e state_d;
  state_e state_q;

  logic        accept;
  logic        capture_id;
  logic        capture_ts;
  logic        timed_out;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expired;

  logic [31:0] id_value_d,  id_value_q;
  logic [31:0] timestamp_d, timestamp_q;
  logic        done_d,      done_q;
  logic        id_match_d,  id_match_q;
  logic        timeout_d,   timeout_q;

  assign accept = avm_read && !avm_waitrequest;

  nios_system_sysid_reader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Data arriving in the acceptance cycle skips the
  // WAIT state, and a capture always beats the timer in the same cycle.
  always_comb begin
    state_d     = state_q;
    capture_id  = 1'b0;
    capture_ts  = 1'b0;
    timed_out   = 1'b0;
    timer_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = REQ_ID;
          timer_clear = 1'b1;
        end
      end
      REQ_ID: begin
        if (accept && avm_readdatavalid) begin
          capture_id  = 1'b1;
          state_d     = REQ_TS;
          timer_clear = 1'b1;
        end else if (timer_expired) begin
          timed_out = 1'b1;
          state_d   = IDLE;
        end else if (accept) begin
          state_d = WAIT_ID;
        end
      end
      WAIT_ID: begin
        if (avm_readdatavalid) begin
          capture_id  = 1'b1;
          state_d     = REQ_TS;
          timer_clear = 1'b1;
        end else if (timer_expired) begin
          timed_out = 1'b1;
          state_d   = IDLE;
        end
      end
      REQ_TS: begin
        if (accept && avm_readdatavalid) begin
          capture_ts = 1'b1;
          state_d    = FINISH;
        end else if (timer_expired) begin
          timed_out = 1'b1;
          state_d   = IDLE;
        end else if (accept) begin
          state_d = WAIT_TS;
        end
      end
      WAIT_TS: begin
        if (avm_readdatavalid) begin
          capture_ts = 1'b1;
          state_d    = FINISH;
        end else if (timer_expired) begin
          timed_out = 1'b1;
          state_d   = IDLE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus and status outputs decoded from the current state
  always_comb begin
    avm_read     = is_request(state_q);
    avm_address  = ((state_q == REQ_TS) || (state_q == WAIT_TS)) ? ADDR_TS : ADDR_ID;
    busy         = (state_q != IDLE);
    timer_enable = (state_q == REQ_ID) || (state_q == WAIT_ID) ||
                   (state_q == REQ_TS) || (state_q == WAIT_TS);
  end

  // Captured data and result flags. id_match is evaluated as the FSM
  // enters FINISH so it is already valid while done is high.
  always_comb begin
    id_value_d  = id_value_q;
    timestamp_d = timestamp_q;
    done_d      = capture_ts || timed_out;
    id_match_d  = id_match_q;
    timeout_d   = timeout_q;
    if (capture_id) begin
      id_value_d = avm_readdata;
    end
    if (capture_ts) begin
      timestamp_d = avm_readdata;
      id_match_d  = (id_value_q == EXPECTED_ID);
    end
    if ((state_q == IDLE) && start) begin
      id_match_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (timed_out) begin
      id_match_d = 1'b0;
      timeout_d  = 1'b1;
    end
  end

  // Result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_value_q  <= '0;
      timestamp_q <= '0;
      done_q      <= 1'b0;
      id_match_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      id_value_q  <= id_value_d;
      timestamp_q <= timestamp_d;
      done_q      <= done_d;
      id_match_q  <= id_match_d;
      timeout_q   <= timeout_d;
    end
  end

  assign id_value  = id_value_q;
  assign timestamp = timestamp_q;
  assign done      = done_q;
  assign id_match  = id_match_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_nios_system_sysid_reader.sv
// Directed testbench for nios_system_sysid_reader. A small behavioural
// Avalon-MM slave with configurable stall, read latency and a mute
// option answers the reads; expected values are hand-computed per test.
module tb_nios_system_sysid_reader;
  import nios_system_sysid_reader_pkg::*;

  localparam logic [31:0] ID_GOOD  = 32'd1738232517;
  localparam logic [31:0] TS_VALUE = 32'd1234;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic [31:0] id_value;
  logic [31:0] timestamp;
  logic        busy;
  logic        done;
  logic        id_match;
  logic        timeout;

  int totalChecks = 0;
  int badChecks   = 0;
  int doneCount   = 0;
  int doneBefore;
  int cycles;

  int          slaveWait    = 0;
  int          slaveLatency = 0;
  bit          slaveMute    = 1'b0;
  int          stallCnt     = 0;
  int          pendingDelay = 0;
  logic [31:0] idData       = ID_GOOD;
  logic [31:0] tsData       = TS_VALUE;
  logic [31:0] pendData     = '0;

  logic [11:0] readPattern;
  logic [11:0] addrPattern;

  nios_system_sysid_reader #(
    .EXPECTED_ID   (ID_GOOD),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata     (avm_readdata),
    .id_value         (id_value),
    .timestamp        (timestamp),
    .busy             (busy),
    .done             (done),
    .id_match         (id_match),
    .timeout          (timeout)
  );

  // 100 MHz clock
  always #5 clock = ~clock;

  // Behavioural slave, driven on the falling edge so the DUT sees stable
  // inputs at the next rising edge. Stalls slaveWait cycles per read, then
  // returns data slaveLatency cycles after acceptance (0 = same cycle).
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      if (pendingDelay > 0) begin
        pendingDelay--;
        if (pendingDelay == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pendData;
        end
      end
      if (avm_read === 1'b1) begin
        if (stallCnt < slaveWait) begin
          avm_waitrequest = 1'b1;
          stallCnt++;
        end else begin
          stallCnt = 0;
          pendData = (avm_address == ADDR_TS) ? tsData : idData;
          if (!(slaveMute && (avm_address == ADDR_ID))) begin
            if (slaveLatency == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata      = pendData;
            end else begin
              pendingDelay = slaveLatency;
            end
          end
        end
      end
    end
  end

  // Counts every cycle in which done is high
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (done === 1'b1) doneCount++;
    end
  end

  // Hard stop in case the sequence logic hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Pulses start for one cycle; returns one cycle later (cycle N+1)
  task automatic applyStimulus();
    start = 1'b1;
    nextCycle();
    start = 1'b0;
  endtask

  task automatic configureSlave(input int waitCycles, input int latency,
                                input bit mute, input logic [31:0] idWord);
    slaveWait    = waitCycles;
    slaveLatency = latency;
    slaveMute    = mute;
    idData       = idWord;
    stallCnt     = 0;
    pendingDelay = 0;
  endtask

  task automatic waitForDone(input int bound, output int n);
    n = 0;
    while ((done !== 1'b1) && (n < bound)) begin
      nextCycle();
      n++;
    end
    checkOutput("done_seen", done, 1'b1);
  endtask

  // Main directed sequence
  initial begin
    reset = 1'b1;
    start = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rst_flags", {avm_address, avm_read, busy, done, id_match, timeout}, 6'b0);
    checkOutput("rst_id_value", id_value, 32'd0);
    checkOutput("rst_timestamp", timestamp, 32'd0);
    reset = 1'b0;
    nextCycle();

    // Zero-wait slave: done three cycles after start is sampled
    configureSlave(0, 0, 1'b0, ID_GOOD);
    applyStimulus();
    checkOutput("zw_req_id", {avm_read, avm_address}, {1'b1, ADDR_ID});
    nextCycle();
    checkOutput("zw_req_ts", {avm_read, avm_address}, {1'b1, ADDR_TS});
    nextCycle();
    checkOutput("zw_done", done, 1'b1);
    checkOutput("zw_id_match", id_match, 1'b1);
    checkOutput("zw_timeout", timeout, 1'b0);
    checkOutput("zw_id_value", id_value, ID_GOOD);
    checkOutput("zw_timestamp", timestamp, TS_VALUE);
    nextCycle();
    checkOutput("zw_done_pulse", done, 1'b0);
    checkOutput("zw_idle", busy, 1'b0);
    checkOutput("zw_match_sticky", id_match, 1'b1);

    // Three stall cycles per read, data two cycles after acceptance
    configureSlave(3, 2, 1'b0, ID_GOOD);
    readPattern = 12'h3CF;
    addrPattern = 12'hFC0;
    applyStimulus();
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("st_read_c%0d", i + 1), avm_read, readPattern[i]);
      checkOutput($sformatf("st_addr_c%0d", i + 1), avm_address, addrPattern[i]);
      nextCycle();
    end
    checkOutput("st_done", done, 1'b1);
    checkOutput("st_id_match", id_match, 1'b1);
    checkOutput("st_timestamp", timestamp, TS_VALUE);
    nextCycle();

    // Slave returns ID 0
    configureSlave(0, 0, 1'b0, 32'd0);
    applyStimulus();
    waitForDone(20, cycles);
    checkOutput("id0_latency", cycles, 2);
    checkOutput("id0_id_match", id_match, 1'b0);
    checkOutput("id0_id_value", id_value, 32'd0);
    nextCycle();

    // ID read accepted but never answered: phase budget of 8 cycles
    configureSlave(0, 0, 1'b1, ID_GOOD);
    applyStimulus();
    waitForDone(30, cycles);
    checkOutput("to_cycles", cycles, 8);
    checkOutput("to_timeout", timeout, 1'b1);
    checkOutput("to_id_match", id_match, 1'b0);
    checkOutput("to_read_bus", {avm_read, busy}, 2'b00);
    checkOutput("to_id_held", id_value, 32'd0);
    checkOutput("to_ts_held", timestamp, TS_VALUE);
    nextCycle();
    checkOutput("to_done_pulse", done, 1'b0);
    checkOutput("to_sticky", timeout, 1'b1);
    configureSlave(0, 0, 1'b0, ID_GOOD);
    applyStimulus();
    checkOutput("to_cleared", timeout, 1'b0);
    waitForDone(20, cycles);
    checkOutput("to_recover_match", id_match, 1'b1);
    nextCycle();

    // Reset while waiting for timestamp data; the late data is ignored
    configureSlave(0, 3, 1'b0, 32'h0BAD_F00D);
    doneBefore = doneCount;
    applyStimulus();
    cycles = 0;
    while (!(busy && !avm_read && (avm_address == ADDR_TS)) && (cycles < 20)) begin
      nextCycle();
      cycles++;
    end
    checkOutput("rw_reach_wait_ts", cycles, 5);
    checkOutput("rw_id_before", id_value, 32'h0BAD_F00D);
    reset = 1'b1;
    #1;
    checkOutput("rw_async_flags", {avm_address, avm_read, busy, done, id_match, timeout}, 6'b0);
    checkOutput("rw_async_id", id_value, 32'd0);
    checkOutput("rw_async_ts", timestamp, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rw_after_flags", {avm_read, busy, done, timeout}, 4'b0);
    checkOutput("rw_after_ts", timestamp, 32'd0);
    nextCycle();
    checkOutput("rw_no_done", doneCount - doneBefore, 0);

    // Second start while reading the timestamp is ignored
    configureSlave(2, 0, 1'b0, ID_GOOD);
    doneBefore = doneCount;
    applyStimulus();
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("dup_in_req_ts", {avm_read, avm_address}, {1'b1, ADDR_TS});
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    waitForDone(20, cycles);
    checkOutput("dup_done_latency", cycles, 2);
    for (int i = 0; i < 8; i++) nextCycle();
    checkOutput("dup_idle", {avm_read, busy}, 2'b00);
    checkOutput("dup_one_done", doneCount - doneBefore, 1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
